// File: rtl/prio_scan_encoder.sv
// rtl/prio_scan_encoder.sv - sequential priority scan encoder over a valid/ready stream
//
// Captures an N-bit request vector and emits the index of every set bit,
// one per accepted transfer, lowest index first (fixed) or starting at a
// rotating pointer (round-robin).
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   load_valid   request vector offered
//   load_ready   block can accept a vector (IDLE)
//   load_vec     request vector, bit i = request i
//   out_valid    out_idx holds a pending request index
//   out_ready    consumer accepts out_idx
//   out_idx      index of selected pending request
//   out_last     selected request is the only one pending
//   pending_cnt  number of set bits still pending
//   zero_load    one-cycle pulse after an all-zero vector was accepted
module prio_scan_encoder #(
   parameter int N           = 12,
   parameter int IDXW        = 4,
   parameter int CNTW        = 4,
   parameter int ROUND_ROBIN = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [N-1:0]    load_vec,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDXW-1:0] out_idx,
   output logic            out_last,
   output logic [CNTW-1:0] pending_cnt,
   output logic            zero_load
);

   typedef enum logic [0:0] {IDLE, SCAN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    pending;
   logic [IDXW-1:0] rr_ptr;
   logic            zero_load_q;

   logic [IDXW-1:0] sel_lo;
   logic [IDXW-1:0] sel_rr;
   logic            has_rr;
   logic [IDXW-1:0] sel_idx;
   logic [N-1:0]    clr_mask;
   logic [CNTW-1:0] cnt;
   logic            accept;
   logic            xfer;

   // Scanning from the top down leaves the lowest qualifying index in each
   // candidate; the round-robin candidate only considers indices at or
   // above rr_ptr and falls back to the plain lowest index when none exist.
   always_comb begin
      sel_lo = '0;
      sel_rr = '0;
      has_rr = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_lo = IDXW'(i);
            if (IDXW'(i) >= rr_ptr) begin
               sel_rr = IDXW'(i);
               has_rr = 1'b1;
            end
         end
      end
      if (ROUND_ROBIN != 0 && has_rr) begin
         sel_idx = sel_rr;
      end else begin
         sel_idx = sel_lo;
      end
   end

   always_comb begin
      cnt      = '0;
      clr_mask = '0;
      for (int i = 0; i < N; i++) begin
         cnt         = cnt + CNTW'(pending[i]);
         clr_mask[i] = (sel_idx == IDXW'(i));
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid && (load_vec != '0)) begin
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            out_valid = (pending != '0);
            if (out_valid && out_ready && (cnt == CNTW'(1))) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept      = load_ready && load_valid;
   assign xfer        = out_valid && out_ready;
   assign out_idx     = sel_idx;
   assign out_last    = (cnt == CNTW'(1));
   assign pending_cnt = cnt;
   assign zero_load   = zero_load_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= '0;
         rr_ptr      <= '0;
         zero_load_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         zero_load_q <= accept && (load_vec == '0);
         if (accept) begin
            pending <= load_vec;
         end else if (xfer) begin
            pending <= pending & ~clr_mask;
         end
         // rr_ptr persists across loads; only reset clears it
         if (ROUND_ROBIN != 0 && xfer) begin
            rr_ptr <= (sel_idx == IDXW'(N - 1)) ? '0 : sel_idx + IDXW'(1);
         end
      end
   end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb/tb_prio_scan_encoder.sv - self-checking bench for prio_scan_encoder
module tb_prio_scan_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        f_load_valid, f_load_ready, f_out_valid, f_out_ready, f_out_last, f_zero_load;
   logic [11:0] f_load_vec;
   logic [3:0]  f_out_idx, f_pending_cnt;

   logic        r_load_valid, r_load_ready, r_out_valid, r_out_ready, r_out_last, r_zero_load;
   logic [11:0] r_load_vec;
   logic [3:0]  r_out_idx, r_pending_cnt;

   always #5 clk = ~clk;

   prio_scan_encoder #(.N(12), .IDXW(4), .CNTW(4), .ROUND_ROBIN(0)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .load_valid(f_load_valid), .load_ready(f_load_ready), .load_vec(f_load_vec),
      .out_valid(f_out_valid), .out_ready(f_out_ready), .out_idx(f_out_idx),
      .out_last(f_out_last), .pending_cnt(f_pending_cnt), .zero_load(f_zero_load)
   );

   prio_scan_encoder #(.N(12), .IDXW(4), .CNTW(4), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .load_valid(r_load_valid), .load_ready(r_load_ready), .load_vec(r_load_vec),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_idx(r_out_idx),
      .out_last(r_out_last), .pending_cnt(r_pending_cnt), .zero_load(r_zero_load)
   );

   typedef struct {
      bit        rr;
      bit        rstn;
      bit        lv;
      bit [11:0] vec;
      bit        ordy;
      bit        elr;
      bit        eov;
      bit [3:0]  eidx;
      bit        elast;
      bit [3:0]  ecnt;
      bit        ezl;
   } step_t;

   step_t tbl[$];
   int    checks = 0;
   int    errors = 0;

   task automatic add(input bit rr, input bit rstn, input bit lv, input bit [11:0] vec,
                      input bit ordy, input bit elr, input bit eov, input bit [3:0] eidx,
                      input bit elast, input bit [3:0] ecnt, input bit ezl);
      step_t s;
      s.rr = rr; s.rstn = rstn; s.lv = lv; s.vec = vec; s.ordy = ordy;
      s.elr = elr; s.eov = eov; s.eidx = eidx; s.elast = elast; s.ecnt = ecnt; s.ezl = ezl;
      tbl.push_back(s);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      // Expected values are the outputs seen before the clock edge of each step.
      //   rr rstn lv vec     ordy | lr ov idx last cnt zl
      // fixed mode: reset/idle
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // fixed: load {9,2,5}
      add(0, 1, 1, 12'h224, 1,  1, 0,  0, 0, 0, 0);
      add(0, 1, 0, 12'h000, 1,  0, 1,  2, 0, 3, 0);
      add(0, 1, 0, 12'h000, 1,  0, 1,  5, 0, 2, 0);
      add(0, 1, 0, 12'h000, 1,  0, 1,  9, 1, 1, 0);
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // backpressure: load {0,11}, 4 stalled cycles, load pulsed during SCAN
      add(0, 1, 1, 12'h801, 0,  1, 0,  0, 0, 0, 0);
      add(0, 1, 0, 12'h000, 0,  0, 1,  0, 0, 2, 0);
      add(0, 1, 1, 12'h0F0, 0,  0, 1,  0, 0, 2, 0);
      add(0, 1, 0, 12'h000, 0,  0, 1,  0, 0, 2, 0);
      add(0, 1, 0, 12'h000, 0,  0, 1,  0, 0, 2, 0);
      add(0, 1, 0, 12'h000, 1,  0, 1,  0, 0, 2, 0);
      add(0, 1, 0, 12'h000, 1,  0, 1, 11, 1, 1, 0);
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // fixed: all-zero load
      add(0, 1, 1, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 1);
      add(0, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // round-robin: {3,7} then {1,3,8}
      add(1, 1, 1, 12'h088, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  3, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  7, 1, 1, 0);
      add(1, 1, 1, 12'h10A, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  8, 0, 3, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  1, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  3, 1, 1, 0);
      // rr wrap: drain 11 (rr_ptr 4 -> 0), then {0,4}
      add(1, 1, 1, 12'h800, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1, 11, 1, 1, 0);
      add(1, 1, 1, 12'h011, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  0, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  4, 1, 1, 0);
      // rr: all-zero load
      add(1, 1, 1, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 1);
      add(1, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // reset mid-scan: rr_ptr=5, load {1,2,3} wraps to 1, then reset
      add(1, 1, 1, 12'h00E, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  1, 0, 3, 0);
      add(1, 0, 0, 12'h000, 0,  0, 1,  2, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);
      // rr_ptr back at 0: {1,11} must start at 1, not 11
      add(1, 1, 1, 12'h802, 0,  1, 0,  0, 0, 0, 0);
      add(1, 1, 0, 12'h000, 0,  0, 1,  1, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1,  1, 0, 2, 0);
      add(1, 1, 0, 12'h000, 1,  0, 1, 11, 1, 1, 0);
      add(1, 1, 0, 12'h000, 1,  1, 0,  0, 0, 0, 0);

      f_load_valid = 1'b0; f_load_vec = '0; f_out_ready = 1'b1;
      r_load_valid = 1'b0; r_load_vec = '0; r_out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         step_t s;
         logic lr, ov, last, zl;
         logic [3:0] idx, cnt;
         s = tbl[i];
         @(negedge clk);
         rst_n        = s.rstn;
         f_load_valid = s.rr ? 1'b0 : s.lv;
         f_load_vec   = s.rr ? 12'h000 : s.vec;
         f_out_ready  = s.rr ? 1'b1 : s.ordy;
         r_load_valid = s.rr ? s.lv : 1'b0;
         r_load_vec   = s.rr ? s.vec : 12'h000;
         r_out_ready  = s.rr ? s.ordy : 1'b1;
         #1;
         lr   = s.rr ? r_load_ready  : f_load_ready;
         ov   = s.rr ? r_out_valid   : f_out_valid;
         idx  = s.rr ? r_out_idx     : f_out_idx;
         last = s.rr ? r_out_last    : f_out_last;
         cnt  = s.rr ? r_pending_cnt : f_pending_cnt;
         zl   = s.rr ? r_zero_load   : f_zero_load;
         chk($sformatf("step%0d load_ready", i), lr, s.elr);
         chk($sformatf("step%0d out_valid", i), ov, s.eov);
         chk($sformatf("step%0d out_idx", i), idx, s.eidx);
         chk($sformatf("step%0d out_last", i), last, s.elast);
         chk($sformatf("step%0d pending_cnt", i), cnt, s.ecnt);
         chk($sformatf("step%0d zero_load", i), zl, s.ezl);
      end

      // Stall stability: load {4,6} into fixed DUT, hold out_ready low and
      // confirm idx/last/cnt never move, then drain with ready held high.
      @(negedge clk);
      f_load_valid = 1'b1; f_load_vec = 12'h050; f_out_ready = 1'b0;
      @(negedge clk);
      f_load_valid = 1'b0; f_load_vec = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d out_idx", k), f_out_idx, 4);
         chk($sformatf("stall%0d pending_cnt", k), f_pending_cnt, 2);
         chk($sformatf("stall%0d out_last", k), f_out_last, 0);
         @(negedge clk);
      end
      f_out_ready = 1'b1;
      #1;
      chk("drain0 out_idx", f_out_idx, 4);
      @(negedge clk);
      #1;
      chk("drain1 out_idx", f_out_idx, 6);
      chk("drain1 out_last", f_out_last, 1);
      @(negedge clk);
      #1;
      chk("drain_done out_valid", f_out_valid, 0);
      chk("drain_done load_ready", f_load_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
